pipeline_ctrl: RTL

Hazard and stall controller for the five-stage MIPS-lite pipeline. It drives the PC write enable, the IF/ID register write enable and flush, the ID/EX bubble insert and a global freeze. It sequences four cases: load-use stalls, taken-branch flushes, memory wait states, and a multi-cycle multiply/divide unit (MDU) busy window. It sits beside the IF/ID and ID/EX pipeline registers and is the only source of their enables.

---
 rtl/pipeline_ctrl_pkg.sv | 15 +
 rtl/pipeline_ctrl_hazard_detect.sv | 30 +++
 rtl/pipeline_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: widths,
// the IF/ID flush value and the MDU sequencer state encoding.
package pipeline_ctrl_pkg;

  localparam int unsigned DEF_REG_ADDR_W = 5;

  // Value loaded into IF/ID on a flush (encodes a NOP)
  localparam logic [31:0] INITIAL_VAL = 32'h0000_0000;

  typedef enum logic {
    PC_IDLE    = 1'b0,
    PC_MDU_RUN = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational hazard compare: load-use against the load in EX, and
// HI/LO or MDU reuse while a multiply/divide is still in flight.
module pipeline_ctrl_hazard_detect #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_uses_hilo,
  input  logic                  id_mdu_start,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  mdu_busy,
  output logic                  lu_hazard,
  output logic                  hilo_hazard
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match    = id_uses_rs && (id_rs == ex_rt);
    rt_match    = id_uses_rt && (id_rt == ex_rt);
    // $zero is never a real destination, so a load to r0 cannot create a hazard
    lu_hazard   = ex_mem_read && (ex_rt != '0) && (rs_match || rt_match);
    hilo_hazard = mdu_busy && (id_uses_hilo || id_mdu_start);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for the five-stage pipeline: priority mux for
// PC / IF/ID / ID/EX enables plus the MDU busy-window sequencer.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned MDU_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_uses_hilo,
  input  logic                  id_mdu_start,
  input  logic                  id_branch_taken,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  mem_stall,
  output logic                  pc_wen,
  output logic                  if_id_wen,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  pipe_freeze,
  output logic                  mdu_go,
  output logic                  mdu_busy
);

  localparam int unsigned CntW = $clog2(MDU_CYCLES);
  localparam logic [CntW-1:0] CntLoad = CntW'(MDU_CYCLES - 1);

  pc_state_e       state_q, state_d;
  logic [CntW-1:0] mdu_cnt_q, mdu_cnt_d;

  logic busy_raw;
  logic lu_hazard;
  logic hilo_hazard;

  logic pc_wen_c, if_id_wen_c, if_id_flush_c, id_ex_bubble_c, pipe_freeze_c, mdu_go_c;

  assign busy_raw = (state_q == PC_MDU_RUN);

  pipeline_ctrl_hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) hazard_detect (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_uses_hilo (id_uses_hilo),
    .id_mdu_start (id_mdu_start),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .mdu_busy     (busy_raw),
    .lu_hazard    (lu_hazard),
    .hilo_hazard  (hilo_hazard)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= PC_IDLE;
      mdu_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  always_comb begin
    pc_wen_c       = 1'b1;
    if_id_wen_c    = 1'b1;
    if_id_flush_c  = 1'b0;
    id_ex_bubble_c = 1'b0;
    pipe_freeze_c  = 1'b0;
    mdu_go_c       = 1'b0;

    if (mem_stall) begin
      pc_wen_c      = 1'b0;
      if_id_wen_c   = 1'b0;
      pipe_freeze_c = 1'b1;
    end else if (hilo_hazard || lu_hazard) begin
      pc_wen_c       = 1'b0;
      if_id_wen_c    = 1'b0;
      id_ex_bubble_c = 1'b1;
    end else begin
      if_id_flush_c = id_branch_taken;
      // A start while busy is already caught as a HI/LO hazard above
      mdu_go_c      = id_mdu_start && !busy_raw;
    end
  end

  // The counter runs regardless of freezes so the MDU window is fixed-length
  always_comb begin
    state_d   = state_q;
    mdu_cnt_d = mdu_cnt_q;
    unique case (state_q)
      PC_IDLE: begin
        if (mdu_go_c) begin
          state_d   = PC_MDU_RUN;
          mdu_cnt_d = CntLoad;
        end
      end
      PC_MDU_RUN: begin
        if (mdu_cnt_q == '0) begin
          state_d = PC_IDLE;
        end else begin
          mdu_cnt_d = mdu_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d   = PC_IDLE;
        mdu_cnt_d = '0;
      end
    endcase
  end

  // Everything is forced low while reset is held, independent of the clock
  always_comb begin
    pc_wen       = rst & pc_wen_c;
    if_id_wen    = rst & if_id_wen_c;
    if_id_flush  = rst & if_id_flush_c;
    id_ex_bubble = rst & id_ex_bubble_c;
    pipe_freeze  = rst & pipe_freeze_c;
    mdu_go       = rst & mdu_go_c;
    mdu_busy     = rst & busy_raw;
  end

endmodule
